// File: rtl/ss_line_buffer_if.sv
// Bus bundle between the save-state client, the one-line cache and DDR arbiter channel 1.
// master = client plus arbiter side, slave = the line buffer.
interface ss_line_buffer_if;
  logic [27:0] ss_addr;
  logic [7:0]  ss_din;
  logic        ss_we;
  logic        ss_rd;
  logic [7:0]  ss_dout;
  logic        ss_ack;
  logic        ss_flush;
  logic        ss_inval;
  logic        flush_done;
  logic [26:0] ch1_addr;
  logic [63:0] ch1_din;
  logic [63:0] ch1_dout;
  logic        ch1_req;
  logic        ch1_rnw;
  logic        ch1_ready;

  modport master (
    output ss_addr, ss_din, ss_we, ss_rd, ss_flush, ss_inval, ch1_dout, ch1_ready,
    input  ss_dout, ss_ack, flush_done, ch1_addr, ch1_din, ch1_req, ch1_rnw
  );

  modport slave (
    input  ss_addr, ss_din, ss_we, ss_rd, ss_flush, ss_inval, ch1_dout, ch1_ready,
    output ss_dout, ss_ack, flush_done, ch1_addr, ch1_din, ch1_req, ch1_rnw
  );
endinterface

// File: rtl/ss_line_buffer.sv
// Single 64-bit line cache turning byte-wide save-state accesses into line reads/writes
// on DDR arbiter channel 1, with write-back on miss, flush, and optional line-end write-back.
module ss_line_buffer #(
  parameter bit WB_ON_LINE_END = 1'b1
) (
  input logic            clk,
  input logic            reset,
  ss_line_buffer_if.slave bus
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;
  localparam int TAG_W     = 25;

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, SERVE} state_e;
  typedef enum logic [1:0] {WB_MISS, WB_FLUSH, WB_LEND} wb_kind_e;

  state_e                             state;
  wb_kind_e                           wb_kind;
  logic [NUM_LANES-1:0][VEC_W-1:0]    line;
  logic [NUM_LANES-1:0][VEC_W-1:0]    hit_line;
  logic [NUM_LANES-1:0][VEC_W-1:0]    fill_line;
  logic [TAG_W-1:0]                   tag;
  logic                               valid, dirty, flush_pend, lend_pend;

  logic [2:0]       lane;
  logic [TAG_W-1:0] req_tag;
  logic             req, hit, d_eff, flush_go;

  assign lane     = bus.ss_addr[2:0];
  assign req_tag  = bus.ss_addr[27:3];
  // Requests are masked during the ack cycle so a held level is not served twice.
  assign req      = (bus.ss_we | bus.ss_rd) & ~bus.ss_ack;
  // A same-cycle invalidate is applied before the request and flush decisions.
  assign hit      = valid & ~bus.ss_inval & (tag == req_tag);
  assign d_eff    = dirty & ~bus.ss_inval;
  assign flush_go = flush_pend | bus.ss_flush;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign hit_line[k]  = (bus.ss_we && lane == 3'(k)) ? bus.ss_din : line[k];
    assign fill_line[k] = (bus.ss_we && lane == 3'(k)) ? bus.ss_din
                                                       : bus.ch1_dout[k*VEC_W +: VEC_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wb_kind        <= WB_MISS;
      line           <= '0;
      tag            <= '0;
      valid          <= 1'b0;
      dirty          <= 1'b0;
      flush_pend     <= 1'b0;
      lend_pend      <= 1'b0;
      bus.ch1_req    <= 1'b0;
      bus.ch1_rnw    <= 1'b1;
      bus.ch1_addr   <= '0;
      bus.ch1_din    <= '0;
      bus.ss_ack     <= 1'b0;
      bus.ss_dout    <= '0;
      bus.flush_done <= 1'b0;
    end else begin
      bus.ss_ack     <= 1'b0;
      bus.flush_done <= 1'b0;
      bus.ch1_req    <= 1'b0;
      if (bus.ss_flush && state != IDLE) flush_pend <= 1'b1;

      case (state)
        IDLE: begin
          lend_pend <= 1'b0;
          if (bus.ss_inval) begin
            valid <= 1'b0;
            dirty <= 1'b0;
          end
          if (flush_go) begin
            flush_pend <= 1'b0;
            if (d_eff) begin
              state        <= WB_REQ;
              wb_kind      <= WB_FLUSH;
              bus.ch1_req  <= 1'b1;
              bus.ch1_rnw  <= 1'b0;
              bus.ch1_addr <= {tag, 2'b00};
              bus.ch1_din  <= line;
            end else begin
              bus.flush_done <= 1'b1;
            end
          end else if (lend_pend && d_eff) begin
            state        <= WB_REQ;
            wb_kind      <= WB_LEND;
            bus.ch1_req  <= 1'b1;
            bus.ch1_rnw  <= 1'b0;
            bus.ch1_addr <= {tag, 2'b00};
            bus.ch1_din  <= line;
          end else if (req) begin
            if (hit) begin
              bus.ss_ack  <= 1'b1;
              bus.ss_dout <= hit_line[lane];
              line        <= hit_line;
              if (bus.ss_we) begin
                dirty     <= 1'b1;
                lend_pend <= WB_ON_LINE_END && (lane == 3'd7);
              end
            end else if (d_eff) begin
              state        <= WB_REQ;
              wb_kind      <= WB_MISS;
              bus.ch1_req  <= 1'b1;
              bus.ch1_rnw  <= 1'b0;
              bus.ch1_addr <= {tag, 2'b00};
              bus.ch1_din  <= line;
            end else begin
              state        <= FILL_REQ;
              bus.ch1_req  <= 1'b1;
              bus.ch1_rnw  <= 1'b1;
              bus.ch1_addr <= {req_tag, 2'b00};
            end
          end
        end
        WB_REQ: state <= WB_WAIT;
        WB_WAIT: begin
          if (bus.ch1_ready) begin
            dirty <= 1'b0;
            case (wb_kind)
              WB_MISS: begin
                state        <= FILL_REQ;
                bus.ch1_req  <= 1'b1;
                bus.ch1_rnw  <= 1'b1;
                bus.ch1_addr <= {req_tag, 2'b00};
              end
              WB_FLUSH: begin
                state          <= IDLE;
                bus.flush_done <= 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        end
        FILL_REQ: state <= FILL_WAIT;
        FILL_WAIT: begin
          // Ack is raised on entry to SERVE so it is high during the SERVE cycle.
          if (bus.ch1_ready) begin
            state       <= SERVE;
            line        <= fill_line;
            tag         <= bus.ch1_addr[26:2];
            valid       <= 1'b1;
            dirty       <= bus.ss_we;
            bus.ss_ack  <= 1'b1;
            bus.ss_dout <= fill_line[lane];
          end
        end
        SERVE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ss_line_buffer.sv
// Scoreboard bench for ss_line_buffer: expected ack / flush_done / ch1 events are queued
// as stimulus is driven and consumed in order as the DUT produces them; DDR is a small model.
module tb_ss_line_buffer;
  typedef enum logic [1:0] {EV_ACK, EV_FLUSH, EV_RD, EV_WR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [26:0] addr;
    logic [63:0] data;
    bit          chk_data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  bit   ddr_late;
  int   n_chk = 0;
  int   n_err = 0;
  ev_t  sb[$];
  logic [63:0] mem [logic [26:0]];

  ss_line_buffer_if bus ();

  ss_line_buffer #(.WB_ON_LINE_END(1'b1)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input ev_kind_e k, input logic [26:0] a, input logic [63:0] d,
                         input bit cd);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.chk_data = cd;
    sb.push_back(e);
  endtask

  task automatic take(input ev_kind_e k, input logic [26:0] a, input logic [63:0] d);
    ev_t e;
    chk("sb_pending", 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("evt_kind", 64'(k), 64'(e.kind));
      if (e.kind == EV_RD || e.kind == EV_WR) chk("ch1_addr", 64'(a), 64'(e.addr));
      if (e.kind == EV_WR) chk("ch1_din", d, e.data);
      if (e.kind == EV_ACK && e.chk_data) chk("ss_dout", d, e.data);
    end
  endtask

  // Monitor: every DUT output event must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.ss_ack)     take(EV_ACK, '0, {56'd0, bus.ss_dout});
      if (bus.flush_done) take(EV_FLUSH, '0, '0);
      if (bus.ch1_req)    take(bus.ch1_rnw ? EV_RD : EV_WR, bus.ch1_addr, bus.ch1_din);
    end
  end

  // DDR channel model.
  initial begin
    logic [26:0] a;
    logic [63:0] d;
    logic        rnw;
    bit          late;
    mem[27'h20]      = 64'h0102030405060708;
    mem[27'h40]      = 64'h1122334455667788;
    mem[27'h80]      = 64'hDEADBEEF01234567;
    mem[27'h100]     = 64'hCAFEF00D0BADBEEF;
    mem[27'h7FFFFFC] = 64'hA500000000000000;
    bus.ch1_ready = 1'b0;
    bus.ch1_dout  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.ch1_req) begin
        a = bus.ch1_addr; d = bus.ch1_din; rnw = bus.ch1_rnw; late = ddr_late;
        repeat (late ? 8 : 3) @(posedge clk);
        #1;
        if (!late) begin
          chk("ch1_addr_hold", 64'(bus.ch1_addr), 64'(a));
          chk("ch1_rnw_hold", 64'(bus.ch1_rnw), 64'(rnw));
          if (!rnw) chk("ch1_din_hold", bus.ch1_din, d);
        end
        if (rnw) bus.ch1_dout = mem.exists(a) ? mem[a] : 64'd0;
        else     mem[a] = d;
        bus.ch1_ready = 1'b1;
        @(posedge clk); #1 bus.ch1_ready = 1'b0;
      end
    end
  end

  task automatic op(input bit we, input logic [27:0] a, input logic [7:0] d,
                    input bit fl, input bit inv, output int lat);
    bit got = 1'b0;
    @(posedge clk); #1;
    bus.ss_addr = a; bus.ss_din = d; bus.ss_we = we; bus.ss_rd = !we;
    bus.ss_flush = fl; bus.ss_inval = inv;
    if (fl || inv) begin
      @(posedge clk); #1;
      bus.ss_flush = 1'b0; bus.ss_inval = 1'b0;
    end
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.ss_ack) begin got = 1'b1; break; end
      lat++;
    end
    bus.ss_we = 1'b0; bus.ss_rd = 1'b0;
    chk("ack_seen", 64'(got), 64'd1);
  endtask

  task automatic flush(output int lat);
    bit got = 1'b0;
    @(posedge clk); #1 bus.ss_flush = 1'b1;
    @(posedge clk); #1 bus.ss_flush = 1'b0;
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.flush_done) begin got = 1'b1; break; end
      lat++;
    end
    chk("flush_seen", 64'(got), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
    repeat (6) @(posedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    rst = 1'b1; ddr_late = 1'b0;
    bus.ss_addr = '0; bus.ss_din = '0; bus.ss_we = 1'b0; bus.ss_rd = 1'b0;
    bus.ss_flush = 1'b0; bus.ss_inval = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss_ack",     64'(bus.ss_ack), 64'd0);
    chk("rst_ss_dout",    64'(bus.ss_dout), 64'd0);
    chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
    chk("rst_ch1_req",    64'(bus.ch1_req), 64'd0);
    chk("rst_ch1_rnw",    64'(bus.ch1_rnw), 64'd1);
    chk("rst_ch1_addr",   64'(bus.ch1_addr), 64'd0);
    chk("rst_ch1_din",    bus.ch1_din, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Byte writes across one line; lane 7 hit triggers the line-end write-back.
    for (int i = 0; i < 8; i++) begin
      if (i == 0) sb_push(EV_RD, 27'h8, '0, 1'b0);
      sb_push(EV_ACK, '0, '0, 1'b0);
      if (i == 7) sb_push(EV_WR, 27'h8, 64'h8877665544332211, 1'b0);
      op(1'b1, 28'h10 + 28'(i), 8'(8'h11 * (i + 1)), 1'b0, 1'b0, lat);
    end
    drain();

    // Read miss fill, then read hit with one-cycle latency.
    sb_push(EV_RD, 27'h80, '0, 1'b0);
    sb_push(EV_ACK, '0, 64'h23, 1'b1);
    op(1'b0, 28'h102, 8'h0, 1'b0, 1'b0, lat);
    sb_push(EV_ACK, '0, 64'hDE, 1'b1);
    op(1'b0, 28'h107, 8'h0, 1'b0, 1'b0, lat);
    chk("hit_lat", 64'(lat), 64'd1);
    sb_push(EV_ACK, '0, '0, 1'b0);
    op(1'b1, 28'h103, 8'h55, 1'b0, 1'b0, lat);
    sb_push(EV_ACK, '0, 64'h55, 1'b1);
    op(1'b0, 28'h103, 8'h0, 1'b0, 1'b0, lat);
    drain();

    // Dirty miss: write-back then fill, write-miss merges into DDR contents.
    sb_push(EV_WR, 27'h80, 64'hDEADBEEF55234567, 1'b0);
    sb_push(EV_RD, 27'h20, '0, 1'b0);
    sb_push(EV_ACK, '0, '0, 1'b0);
    op(1'b1, 28'h40, 8'hAA, 1'b0, 1'b0, lat);
    sb_push(EV_WR, 27'h20, 64'h01020304050607AA, 1'b0);
    sb_push(EV_RD, 27'h40, '0, 1'b0);
    sb_push(EV_ACK, '0, 64'h88, 1'b1);
    op(1'b0, 28'h80, 8'h0, 1'b0, 1'b0, lat);
    drain();

    // Flush dirty, flush clean, line still valid afterwards.
    sb_push(EV_ACK, '0, '0, 1'b0);
    op(1'b1, 28'h81, 8'h3C, 1'b0, 1'b0, lat);
    sb_push(EV_WR, 27'h40, 64'h1122334455663C88, 1'b0);
    sb_push(EV_FLUSH, '0, '0, 1'b0);
    flush(lat);
    drain();
    sb_push(EV_FLUSH, '0, '0, 1'b0);
    flush(lat);
    chk("flush_clean_lat", 64'(lat), 64'd0);
    sb_push(EV_ACK, '0, 64'h3C, 1'b1);
    op(1'b0, 28'h81, 8'h0, 1'b0, 1'b0, lat);
    chk("post_flush_hit_lat", 64'(lat), 64'd1);
    drain();

    // Flush coinciding with a dirty read miss: flush first.
    sb_push(EV_ACK, '0, '0, 1'b0);
    op(1'b1, 28'h82, 8'h77, 1'b0, 1'b0, lat);
    sb_push(EV_WR, 27'h40, 64'h1122334455773C88, 1'b0);
    sb_push(EV_FLUSH, '0, '0, 1'b0);
    sb_push(EV_RD, 27'h100, '0, 1'b0);
    sb_push(EV_ACK, '0, 64'hEF, 1'b1);
    op(1'b0, 28'h200, 8'h0, 1'b1, 1'b0, lat);
    drain();

    // Reset during FILL_WAIT; the late ch1_ready must be ignored.
    ddr_late = 1'b1;
    sb_push(EV_RD, 27'h180, '0, 1'b0);
    @(posedge clk); #1;
    bus.ss_addr = 28'h300; bus.ss_rd = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ch1_req) begin seen = 1'b1; break; end
    end
    chk("fill_req_seen", 64'(seen), 64'd1);
    @(posedge clk); #1 rst = 1'b1; bus.ss_rd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    ddr_late = 1'b0;
    drain();
    sb_push(EV_RD, 27'h100, '0, 1'b0);
    sb_push(EV_ACK, '0, 64'hEF, 1'b1);
    op(1'b0, 28'h200, 8'h0, 1'b0, 1'b0, lat);
    drain();

    // Invalidate with a coinciding request: request refills.
    sb_push(EV_RD, 27'h100, '0, 1'b0);
    sb_push(EV_ACK, '0, 64'hBE, 1'b1);
    op(1'b0, 28'h201, 8'h0, 1'b0, 1'b1, lat);
    drain();

    // Top tag: address forwarded unchanged, lane-7 write hit writes back.
    sb_push(EV_RD, 27'h7FFFFFC, '0, 1'b0);
    sb_push(EV_ACK, '0, 64'hA5, 1'b1);
    op(1'b0, 28'hFFFFFFF, 8'h0, 1'b0, 1'b0, lat);
    sb_push(EV_ACK, '0, '0, 1'b0);
    sb_push(EV_WR, 27'h7FFFFFC, 64'h5A00000000000000, 1'b0);
    op(1'b1, 28'hFFFFFFF, 8'h5A, 1'b0, 1'b0, lat);
    chk("lend_hit_lat", 64'(lat), 64'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
